// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: expands PUSH/POP/STMIA/LDMIA register lists into per-register
// transfer micro-ops plus an optional base-writeback micro-op.  Rev 1.0
`default_nettype none

module reg_list_sequencer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [8:0]  reg_list_i,
    input  logic [3:0]  base_reg_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        stall_pipeline_o,
    output logic        uop_valid_o,
    output logic        uop_load_o,
    output logic [3:0]  uop_reg_addr_o,
    output logic [3:0]  uop_base_addr_o,
    output logic [31:0] uop_offset_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_imm_o,
    output logic        done_o
);

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_LDMIA = 2'b11;
    localparam logic [3:0] SP_REG   = 4'd13;
    localparam logic [3:0] IDX_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        WB   = 2'b10
    } state_t;

    state_t      state, state_n;
    logic [1:0]  op, op_n;
    logic [8:0]  remaining, remaining_n;
    logic [3:0]  idx, idx_n;
    logic [3:0]  count, count_n;
    logic [3:0]  base, base_n;
    logic        skip_wb, skip_wb_n;
    logic        done, done_n;

    logic [8:0]  eff_list;
    logic        is_stack_op;
    logic        accept;
    logic        last_xfer;
    logic [3:0]  low_bit;
    logic [31:0] idx_bytes;
    logic [31:0] count_bytes;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Bit 8 (lr/pc) only exists for the stack forms.
    assign is_stack_op = (op_i == OP_PUSH) || (op_i == OP_POP);
    assign eff_list    = is_stack_op ? reg_list_i : {1'b0, reg_list_i[7:0]};
    assign accept      = (state == IDLE) && start_i && !hold_i && !flush_i;
    assign last_xfer   = ((remaining & (remaining - 9'd1)) == 9'd0);

    always_comb begin
        low_bit = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (remaining[i]) begin
                low_bit = 4'(i);
            end
        end
    end

    assign idx_bytes   = {26'd0, idx, 2'b00};
    assign count_bytes = {26'd0, count, 2'b00};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            op        <= 2'b00;
            remaining <= 9'd0;
            idx       <= 4'd0;
            count     <= 4'd0;
            base      <= 4'd0;
            skip_wb   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            op        <= op_n;
            remaining <= remaining_n;
            idx       <= idx_n;
            count     <= count_n;
            base      <= base_n;
            skip_wb   <= skip_wb_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        op_n        = op;
        remaining_n = remaining;
        idx_n       = idx;
        count_n     = count;
        base_n      = base;
        skip_wb_n   = skip_wb;
        done_n      = 1'b0;

        if (flush_i) begin
            state_n     = IDLE;
            remaining_n = 9'd0;
        end else if (!hold_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (eff_list == 9'd0) begin
                            done_n = 1'b1;
                        end else begin
                            state_n     = XFER;
                            op_n        = op_i;
                            remaining_n = eff_list;
                            idx_n       = 4'd0;
                            count_n     = popcount9(eff_list);
                            base_n      = is_stack_op ? SP_REG : base_reg_i;
                            // LDMIA that reloads its own base must not overwrite it afterwards.
                            skip_wb_n   = (op_i == OP_LDMIA) && !base_reg_i[3] &&
                                          reg_list_i[base_reg_i[2:0]];
                        end
                    end
                end
                XFER: begin
                    remaining_n = remaining & (remaining - 9'd1);
                    idx_n       = (idx == IDX_MAX) ? IDX_MAX : idx + 4'd1;
                    if (last_xfer) begin
                        if (skip_wb) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = WB;
                        end
                    end
                end
                WB: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_o           = (state != IDLE);
        uop_valid_o      = (state == XFER);
        wb_valid_o       = (state == WB);
        done_o           = done;
        uop_base_addr_o  = base;
        stall_pipeline_o = (accept && (eff_list != 9'd0)) || (state == XFER) ||
                           ((state == WB) && hold_i);
        uop_load_o       = 1'b0;
        uop_reg_addr_o   = 4'd0;
        uop_offset_o     = 32'h0;
        wb_imm_o         = 32'h0;
        if (state == XFER) begin
            uop_load_o     = op[0];
            uop_reg_addr_o = (low_bit == 4'd8) ? ((op == OP_POP) ? 4'd15 : 4'd14) : low_bit;
            uop_offset_o   = (op == OP_PUSH) ? (idx_bytes - count_bytes) : idx_bytes;
        end
        if (state == WB) begin
            wb_imm_o = (op == OP_PUSH) ? (32'h0 - count_bytes) : count_bytes;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_list_sequencer.sv
// tb_reg_list_sequencer: directed scoreboard bench for reg_list_sequencer.  Rev 1.0
`default_nettype none

module tb_reg_list_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [8:0]  reg_list;
    logic [3:0]  base_reg;
    logic        hold;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        uop_valid;
    logic        uop_load;
    logic [3:0]  uop_reg;
    logic [3:0]  uop_base;
    logic [31:0] uop_off;
    logic        wb_valid;
    logic [31:0] wb_imm;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = -1;

    logic [74:0] sb[$];

    reg_list_sequencer dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .start_i          (start),
        .op_i             (op),
        .reg_list_i       (reg_list),
        .base_reg_i       (base_reg),
        .hold_i           (hold),
        .flush_i          (flush),
        .busy_o           (busy),
        .stall_pipeline_o (stall),
        .uop_valid_o      (uop_valid),
        .uop_load_o       (uop_load),
        .uop_reg_addr_o   (uop_reg),
        .uop_base_addr_o  (uop_base),
        .uop_offset_o     (uop_off),
        .wb_valid_o       (wb_valid),
        .wb_imm_o         (wb_imm),
        .done_o           (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [74:0] mk_uop(input logic ld, input logic [3:0] r, input logic [3:0] b,
                                           input logic [31:0] off);
        return {2'd0, ld, r, b, off, 32'd0};
    endfunction

    function automatic logic [74:0] mk_wb(input logic [31:0] imm);
        return {2'd1, 9'd0, 32'd0, imm};
    endfunction

    function automatic logic [74:0] mk_done();
        return {2'd2, 73'd0};
    endfunction

    task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: outputs are frozen under hold, so the head entry is only retired when hold is low.
    always @(negedge clk) begin
        logic [74:0] obs;
        if (reset_n) begin
            check("valid_exclusive", {74'd0, uop_valid & wb_valid}, 75'd0);
            if (uop_valid) check("stall_in_xfer", {74'd0, stall}, 75'd1);
            if (wb_valid)  check("stall_in_wb", {74'd0, stall}, {74'd0, hold});
            if (uop_valid || wb_valid || done) begin
                if (uop_valid)     obs = mk_uop(uop_load, uop_reg, uop_base, uop_off);
                else if (wb_valid) obs = mk_wb(wb_imm);
                else               obs = mk_done();
                if (done) done_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_output", obs, {2'd3, 73'd0});
                end else begin
                    check("scoreboard", obs, sb[0]);
                    if (!hold || (obs[74:73] == 2'd2)) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [8:0] l, input logic [3:0] b,
                         input logic exp_stall);
        start    = 1'b1;
        op       = o;
        reg_list = l;
        base_reg = b;
        #1;
        check("stall_on_start", {74'd0, stall}, {74'd0, exp_stall});
        tick();
        start    = 1'b0;
        reg_list = 9'd0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (((sb.size() != 0) || busy) && (n < budget)) begin
            tick();
            n++;
        end
        check("drain_in_budget", {74'd0, n < budget}, 75'd1);
        sb.delete();
        repeat (2) tick();
    endtask

    initial begin
        int start_cyc;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; reg_list = 9'd0; base_reg = 4'd0;
        hold = 1'b0; flush = 1'b0;
        #1;
        check("reset_outputs", {busy, stall, uop_valid, uop_load, wb_valid, done,
                                uop_reg, uop_base, uop_off, wb_imm}, 75'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // PUSH {r4,r5,lr}
        sb.push_back(mk_uop(1'b0, 4'd4, 4'd13, -32'd12));
        sb.push_back(mk_uop(1'b0, 4'd5, 4'd13, -32'd8));
        sb.push_back(mk_uop(1'b0, 4'd14, 4'd13, -32'd4));
        sb.push_back(mk_wb(-32'd12));
        sb.push_back(mk_done());
        start_cyc = cyc;
        issue(2'b00, 9'h130, 4'd7, 1'b1);
        drain(20);
        check("push_latency", 75'(done_cyc - start_cyc), 75'd5);

        // POP {r0,pc} with hold over the first transfer
        sb.push_back(mk_uop(1'b1, 4'd0, 4'd13, 32'd0));
        sb.push_back(mk_uop(1'b1, 4'd15, 4'd13, 32'd4));
        sb.push_back(mk_wb(32'd8));
        sb.push_back(mk_done());
        issue(2'b01, 9'h101, 4'd0, 1'b1);
        hold = 1'b1;
        tick();
        tick();
        hold = 1'b0;
        drain(20);

        // LDMIA r2!,{r1,r2}; bit 8 must be ignored and writeback skipped
        sb.push_back(mk_uop(1'b1, 4'd1, 4'd2, 32'd0));
        sb.push_back(mk_uop(1'b1, 4'd2, 4'd2, 32'd4));
        sb.push_back(mk_done());
        issue(2'b11, 9'h106, 4'd2, 1'b1);
        drain(20);

        // Empty effective lists are NOPs
        sb.push_back(mk_done());
        issue(2'b01, 9'h000, 4'd0, 1'b0);
        check("nop_pop_busy", {74'd0, busy}, 75'd0);
        drain(10);
        sb.push_back(mk_done());
        issue(2'b10, 9'h100, 4'd3, 1'b0);
        check("nop_stmia_busy", {74'd0, busy}, 75'd0);
        drain(10);

        // STMIA r3!,{r0-r7} with hold during writeback
        for (int k = 0; k < 8; k++) sb.push_back(mk_uop(1'b0, 4'(k), 4'd3, 32'(4 * k)));
        sb.push_back(mk_wb(32'd32));
        sb.push_back(mk_done());
        issue(2'b10, 9'h1FF, 4'd3, 1'b1);
        repeat (8) tick();
        hold = 1'b1;
        tick();
        hold = 1'b0;
        drain(20);

        // PUSH of all nine registers
        for (int k = 0; k < 9; k++)
            sb.push_back(mk_uop(1'b0, (k == 8) ? 4'd14 : 4'(k), 4'd13, 32'(4 * k - 36)));
        sb.push_back(mk_wb(-32'd36));
        sb.push_back(mk_done());
        issue(2'b00, 9'h1FF, 4'd0, 1'b1);
        drain(30);

        // Flush during second of four PUSH transfers, restart immediately
        sb.push_back(mk_uop(1'b0, 4'd0, 4'd13, -32'd16));
        sb.push_back(mk_uop(1'b0, 4'd1, 4'd13, -32'd12));
        issue(2'b00, 9'h00F, 4'd0, 1'b1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {72'd0, busy, uop_valid, wb_valid}, 75'd0);
        sb.push_back(mk_uop(1'b0, 4'd6, 4'd5, 32'd0));
        sb.push_back(mk_uop(1'b0, 4'd7, 4'd5, 32'd4));
        sb.push_back(mk_wb(32'd8));
        sb.push_back(mk_done());
        issue(2'b10, 9'h0C0, 4'd5, 1'b1);
        drain(20);

        // Asynchronous reset mid-XFER, then a fresh sequence
        sb.push_back(mk_uop(1'b1, 4'd0, 4'd13, 32'd0));
        issue(2'b01, 9'h00F, 4'd0, 1'b1);
        #5;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, stall, uop_valid, uop_load, wb_valid, done,
                                      uop_reg, uop_base, uop_off, wb_imm}, 75'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_reset_queue", 75'(sb.size()), 75'd0);
        sb.push_back(mk_uop(1'b1, 4'd0, 4'd0, 32'd0));
        sb.push_back(mk_uop(1'b1, 4'd3, 4'd0, 32'd4));
        sb.push_back(mk_done());
        issue(2'b11, 9'h009, 4'd0, 1'b1);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/reg_list_sequencer.md
REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start_i  input  1  decode holds a valid multi-register instruction.
REQ-004 SHALL have port: op_i  input  2  00 PUSH, 01 POP, 10 STMIA, 11 LDMIA.
REQ-005 SHALL have port: reg_list_i  input  9  bits 0-7 select r0-r7; bit 8 selects r14 (PUSH) or r15 (POP), ignored for STMIA/LDMIA.
REQ-006 SHALL have port: base_reg_i  input  4  base register address; r13 forced for PUSH/POP.
REQ-007 SHALL have port: hold_i  input  1  downstream stall (hazard or memory); freezes sequencing.
REQ-008 SHALL have port: flush_i  input  1  pipeline flush; aborts sequence.
REQ-009 SHALL have port: busy_o  output  1  state is not IDLE.
REQ-010 SHALL have port: stall_pipeline_o  output  1  holds fetch/decode registers.
REQ-011 SHALL have port: uop_valid_o  output  1  transfer micro-op presented this cycle.
REQ-012 SHALL have port: uop_load_o  output  1  1 = load (POP/LDMIA), 0 = store.
REQ-013 SHALL have port: uop_reg_addr_o  output  4  data register of this transfer.
REQ-014 SHALL have port: uop_base_addr_o  output  4  latched base register.
REQ-015 SHALL have port: uop_offset_o  output  32  signed byte offset added to base.
REQ-016 SHALL have port: wb_valid_o  output  1  base-writeback micro-op presented.
REQ-017 SHALL have port: wb_imm_o  output  32  signed value added to base on writeback.
REQ-018 SHALL have port: done_o  output  1  one-cycle pulse when sequence completes.

Function
REQ-019 SHALL implement FSM states IDLE, XFER, WB.
REQ-020 In IDLE, start_i=1 with nonzero effective list (hold_i=0, flush_i=0) SHALL latch op, list, base and count=popcount(effective list), then go to XFER at that edge.
REQ-021 start_i with an empty effective list SHALL be a NOP: state stays IDLE, done_o pulses the next cycle, no micro-ops.
REQ-022 start_i SHALL be ignored outside IDLE.
REQ-023 XFER SHALL emit one micro-op per unstalled cycle, registers in ascending address order; first uop_valid_o in the cycle after acceptance.
REQ-024 Offset for k-th transfer (k = 0..count-1) SHALL be 4k for POP/STMIA/LDMIA and 4k-4*count for PUSH, computed in 32-bit two's complement.
REQ-025 After the last transfer, the FSM SHALL enter WB, except that LDMIA with base in list SHALL skip WB and complete directly.
REQ-026 WB SHALL assert wb_valid_o for one unstalled cycle with wb_imm_o = -4*count (PUSH) or +4*count (all others).
REQ-027 done_o SHALL pulse for one cycle on the edge leaving the final micro-op state; FSM returns to IDLE.
REQ-028 hold_i=1 SHALL freeze state, index and all outputs; valid outputs stay asserted unchanged.
REQ-029 stall_pipeline_o SHALL be asserted combinationally in IDLE on accepted start_i, throughout XFER, and in the final micro-op cycle only while hold_i=1.
REQ-030 flush_i SHALL have priority over hold_i and start_i: next edge forces IDLE, all valids low, no done_o.
REQ-031 uop_valid_o and wb_valid_o SHALL never be asserted in the same cycle.
REQ-032 Index/count counters SHALL be 4 bits, saturating at 9; no wrap-around.

Reset
REQ-033 reset_i low SHALL immediately force IDLE; busy_o, stall_pipeline_o, uop_valid_o, uop_load_o, wb_valid_o, done_o = 0; uop_reg_addr_o, uop_base_addr_o = 0; uop_offset_o, wb_imm_o = 32'h0.
REQ-034 Reset asserted mid-sequence SHALL abandon the sequence without done_o; first accepted start_i after release SHALL begin a fresh sequence.

Verification
REQ-035 PUSH {r4,r5,lr} -> three uops r4/-12, r5/-8, r14/-4 (stores, base r13), then WB wb_imm_o=-12, done_o pulse; five cycles start to done.
REQ-036 POP {r0,pc} with hold_i high two cycles during first uop -> r0/+0 held three cycles, then r15/+4, WB +8, done_o.
REQ-037 LDMIA r2!,{r1,r2} -> loads r1/+0, r2/+4, no wb_valid_o, done_o after second uop.
REQ-038 STMIA r3!,{} and POP {} with bit8 clear -> no uops, done_o one cycle later, busy_o stays 0.
REQ-039 flush_i during second of four PUSH transfers -> IDLE next edge, all valids 0, no done_o; new start accepted next cycle.
REQ-040 reset_i low mid-XFER -> outputs 0 asynchronously, no done_o after release.
